// File: rtl/mac_result_fifo_if.sv
// mac_result_fifo_if: capture-side mac bus plus valid/ready drain port of the result FIFO.
interface mac_result_fifo_if #(parameter int AW = 3);
    logic [2:0]  instruction;
    logic        capture;
    logic        stall_in;
    logic        stall;
    logic [31:0] mac_result;
    logic [7:0]  mac_protect;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
    logic        out_mode8;
    logic [1:0]  out_ovf;
    logic [AW:0] count;
    modport master (
        output instruction, capture, stall_in, mac_result, mac_protect, out_ready,
        input  stall, out_valid, out_data, out_mode8, out_ovf, count
    );
    modport slave (
        input  instruction, capture, stall_in, mac_result, mac_protect, out_ready,
        output stall, out_valid, out_data, out_mode8, out_ovf, count
    );
endinterface

// File: rtl/mac_result_fifo.sv
// mac_result_fifo: follows tagged instructions through mac's 3-stage pipe and queues their results;
// stalls mac early enough that every tag in flight already owns a FIFO slot.
module mac_result_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input logic clk,
    input logic reset,
    mac_result_fifo_if.slave bus
);
    // tag pipe entries are {tag, mode8}
    logic [1:0]    t1, t2, t3;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   cnt, inflight;
    logic [AW+1:0] occ;
    logic [42:0]   mem [DEPTH];
    logic [42:0]   head, last, entry;
    logic [1:0]    ovf;
    logic          advance, push, pop, unused_instr;
    assign unused_instr = ^bus.instruction[1:0];
    assign inflight = (AW+1)'(t1[1]) + (AW+1)'(t2[1]) + (AW+1)'(t3[1]);
    assign occ = {1'b0, cnt} + {1'b0, inflight};
    assign bus.stall = bus.stall_in | (occ >= (AW+2)'(DEPTH));
    assign advance = !bus.stall;
    assign push = t3[1];
    assign pop = bus.out_valid & bus.out_ready;
    // overflow = protect bits are not a plain sign extension of the lane(s) below them
    always_comb ovf = t3[0] ? {bus.mac_protect[7:4] != {4{bus.mac_result[31]}},
                               bus.mac_protect[3:0] != {4{bus.mac_result[15]}}}
                            : {1'b0, bus.mac_protect != {8{bus.mac_result[31]}}};
    assign entry = {ovf, t3[0], bus.mac_protect, bus.mac_result};
    assign head = mem[rd_ptr];
    assign bus.out_valid = cnt != '0;
    assign {bus.out_ovf, bus.out_mode8, bus.out_data} = bus.out_valid ? head : last;
    assign bus.count = cnt;
    always_ff @(posedge clk)
        if (push) mem[wr_ptr] <= entry;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            t1 <= '0;
            t2 <= '0;
            t3 <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            last <= '0;
        end else begin
            if (advance) begin
                t1 <= {bus.capture, bus.instruction[2]};
                t2 <= t1;
            end
            t3 <= advance ? t2 : '0;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            cnt <= cnt + (AW+1)'(push) - (AW+1)'(pop);
            if (bus.out_valid) last <= head;
        end
    end
    assert property (@(posedge clk) disable iff (reset) !(push && cnt == (AW+1)'(DEPTH)));
endmodule

// File: tb/tb_mac_result_fifo.sv
// tb_mac_result_fifo: directed and random stimulus against a queue-based model of tagged capture.
module tb_mac_result_fifo;
    localparam int DEPTH = 8;
    localparam int AW = 3;
    logic clk = 0;
    logic reset = 1;
    always #5 clk = ~clk;
    mac_result_fifo_if #(.AW(AW)) bus ();
    mac_result_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
    // an in-flight capture: age 1..3 = how many pipeline stages it has reached
    typedef struct {int age; logic m;} pend_t;
    pend_t pend[$];
    logic [42:0] fq[$];
    logic [42:0] last_e = '0;
    int total = 0;
    int bad = 0;
    function automatic logic [42:0] mk(logic m, logic [31:0] r, logic [7:0] p);
        logic [1:0] o;
        if (m) o = {p[7:4] != {4{r[31]}}, p[3:0] != {4{r[15]}}};
        else   o = {1'b0, p != {8{r[31]}}};
        return {o, m, p, r};
    endfunction
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    function automatic logic model_stall(logic sin);
        return sin | (fq.size() + pend.size() >= DEPTH);
    endfunction
    task automatic check_out();
        chk("stall", 64'(bus.stall), 64'(model_stall(bus.stall_in)));
        chk("valid", 64'(bus.out_valid), 64'(fq.size() > 0));
        chk("count", 64'(bus.count), 64'(fq.size()));
        chk("head", 64'({bus.out_ovf, bus.out_mode8, bus.out_data}), 64'(fq.size() > 0 ? fq[0] : last_e));
    endtask
    task automatic step(input logic cap, input logic [2:0] ins, input logic sin, input logic rdy,
                        input logic [31:0] r, input logic [7:0] p);
        logic adv;
        pend_t np[$];
        @(negedge clk);
        bus.capture = cap;
        bus.instruction = ins;
        bus.stall_in = sin;
        bus.out_ready = rdy;
        bus.mac_result = r;
        bus.mac_protect = p;
        #1 check_out();
        adv = !model_stall(sin);
        @(posedge clk);
        if (fq.size() > 0) begin
            last_e = fq[0];
            if (rdy) void'(fq.pop_front());
        end
        foreach (pend[i]) begin
            if (pend[i].age == 3) fq.push_back(mk(pend[i].m, r, p));
            else np.push_back('{adv ? pend[i].age + 1 : pend[i].age, pend[i].m});
        end
        if (adv && cap) np.push_back('{1, ins[2]});
        pend = np;
    endtask
    task automatic rstep(input logic cap, input logic [2:0] ins, input logic sin, input logic rdy);
        step(cap, ins, sin, rdy, $urandom, 8'($urandom));
    endtask
    task automatic issue(input logic [2:0] ins, input logic [31:0] r, input logic [7:0] p);
        rstep(1, ins, 0, 0);
        rstep(0, 3'b000, 0, 0);
        rstep(0, 3'b000, 0, 0);
        step(0, 3'b000, 0, 0, r, p);
    endtask
    task automatic do_reset();
        @(negedge clk);
        bus.capture = 0;
        bus.stall_in = 0;
        bus.out_ready = 0;
        reset = 1;
        #1;
        pend.delete();
        fq.delete();
        last_e = '0;
        check_out();
        @(posedge clk);
        @(negedge clk);
        reset = 0;
    endtask
    initial begin
        bus.capture = 0;
        bus.instruction = 0;
        bus.stall_in = 0;
        bus.out_ready = 0;
        bus.mac_result = 0;
        bus.mac_protect = 0;
        do_reset();
        rstep(0, 3'b000, 1, 0);
        rstep(0, 3'b000, 0, 1);
        // single MUL result, then drain with ready high
        issue(3'b001, 32'hFFFF_FFF1, 8'hFF);
        rstep(0, 3'b000, 0, 1);
        rstep(0, 3'b000, 0, 1);
        // fill to DEPTH with ready low, then drain in order
        for (int i = 0; i < 14; i++) rstep(1, 3'b001, 0, 0);
        for (int i = 0; i < 11; i++) rstep(0, 3'b000, 0, 1);
        // overflowing MAC, saturated result, 8-bit lanes
        issue(3'b010, 32'h3FFF_0001, 8'h01);
        issue(3'b011, 32'h7FFF_FFFF, 8'h00);
        issue(3'b101, 32'h4000_3F01, 8'h00);
        issue(3'b101, 32'h4000_3F01, 8'h10);
        issue(3'b101, 32'h8000_8001, 8'hF0);
        for (int i = 0; i < 7; i++) rstep(0, 3'b000, 0, 1);
        // stall_in pulses with tags in t1/t2
        rstep(1, 3'b001, 0, 0);
        rstep(1, 3'b101, 0, 0);
        for (int i = 0; i < 3; i++) rstep(0, 3'b000, 1, 0);
        for (int i = 0; i < 5; i++) rstep(0, 3'b000, 0, 0);
        // full FIFO with continuous push/pop
        for (int i = 0; i < 12; i++) rstep(1, 3'b010, 0, 0);
        for (int i = 0; i < 12; i++) rstep(1, 3'b010, 0, 1);
        for (int i = 0; i < 10; i++) rstep(0, 3'b000, 0, 1);
        // random traffic
        for (int i = 0; i < 400; i++)
            rstep(1'($urandom), 3'($urandom), $urandom_range(0, 4) == 0, 1'($urandom));
        for (int i = 0; i < 12; i++) rstep(0, 3'b000, 0, 1);
        // reset with 4 stored and 3 in flight
        for (int i = 0; i < 4; i++) rstep(1, 3'b001, 0, 0);
        for (int i = 0; i < 3; i++) rstep(0, 3'b000, 0, 0);
        for (int i = 0; i < 3; i++) rstep(1, 3'b001, 0, 0);
        do_reset();
        for (int i = 0; i < 6; i++) rstep(0, 3'b000, 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
